// File: rtl/decode_pixel_packer_if.sv
// Pixel-in / packed-word-out stream bundle for decode_pixel_packer.
// Signal names keep the original port names so existing connections map one-to-one.
interface decode_pixel_packer_if #(
   parameter int unsigned PIXEL_BIT       = 8,
   parameter int unsigned PIXELS_PER_WORD = 4,
   parameter int unsigned FRAME_CTR_BIT   = 16
);
   logic [PIXEL_BIT-1:0]                 dn_veri_i;
   logic                                 dn_gecerli_i;
   logic                                 dn_hazir_o;
   logic [PIXEL_BIT*PIXELS_PER_WORD-1:0] pk_veri_o;
   logic [PIXELS_PER_WORD-1:0]           pk_keep_o;
   logic                                 pk_son_o;
   logic                                 pk_gecerli_o;
   logic                                 pk_hazir_i;
   logic [FRAME_CTR_BIT-1:0]             cerceve_sayisi_o;

   modport slave (
      input  dn_veri_i, dn_gecerli_i, pk_hazir_i,
      output dn_hazir_o, pk_veri_o, pk_keep_o, pk_son_o, pk_gecerli_o, cerceve_sayisi_o
   );

   modport master (
      output dn_veri_i, dn_gecerli_i, pk_hazir_i,
      input  dn_hazir_o, pk_veri_o, pk_keep_o, pk_son_o, pk_gecerli_o, cerceve_sayisi_o
   );
endinterface

// File: rtl/decode_pixel_packer.sv
// Packs raster pixels into PIXELS_PER_WORD-lane words with frame-end keep/son marking.
// Optional DECODE_PACKER_CHECKSUM_EN appends a per-frame 32-bit pixel-sum word.
module decode_pixel_packer #(
   parameter int unsigned PIXEL_BIT       = 8,
   parameter int unsigned PIXELS_PER_WORD = 4,
   parameter int unsigned IMG_WIDTH       = 320,
   parameter int unsigned IMG_HEIGHT      = 240,
   parameter int unsigned FRAME_CTR_BIT   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   decode_pixel_packer_if.slave  bus
);
   localparam int unsigned WORD_W = PIXEL_BIT * PIXELS_PER_WORD;
   localparam int unsigned TOTAL  = IMG_WIDTH * IMG_HEIGHT;
   localparam int unsigned LANE_W = $clog2(PIXELS_PER_WORD);
   localparam int unsigned PIX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIXELS_PER_WORD - 1);
   localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(TOTAL - 1);

   logic [LANE_W-1:0]          r_lane;
   logic [PIX_W-1:0]           r_pix_cnt;
   logic [WORD_W-1:0]          r_asm;
   logic [WORD_W-1:0]          r_data;
   logic [PIXELS_PER_WORD-1:0] r_keep;
   logic                       r_son;
   logic                       r_gecerli;
   logic [FRAME_CTR_BIT-1:0]   r_frames;

   logic                       w_last;
   logic                       w_complete;
   logic                       w_in_ok;
   logic                       w_ready;
   logic                       w_in_xfer;
   logic                       w_out_xfer;
   logic [WORD_W-1:0]          w_word;
   logic [PIXELS_PER_WORD-1:0] w_keep;

`ifdef DECODE_PACKER_CHECKSUM_EN
   typedef enum logic [1:0] {ST_DATA, ST_CK_LOAD, ST_CK_OUT} state_t;
   state_t      r_state;
   logic [31:0] r_sum;
   assign w_in_ok = (r_state == ST_DATA);
`else
   assign w_in_ok = 1'b1;
`endif

   // Lanes above the current one stay zero because r_asm is cleared after every word.
   for (genvar k = 0; k < PIXELS_PER_WORD; k++) begin : g_lane
      assign w_word[k*PIXEL_BIT +: PIXEL_BIT] = (r_lane == LANE_W'(k)) ? bus.dn_veri_i
                                                                      : r_asm[k*PIXEL_BIT +: PIXEL_BIT];
      assign w_keep[k] = (r_lane >= LANE_W'(k));
   end

   assign w_last     = (r_pix_cnt == LAST_PIX);
   assign w_complete = (r_lane == LAST_LANE) || w_last;
   assign w_ready    = !rst_i && w_in_ok && (!w_complete || !r_gecerli || bus.pk_hazir_i);
   assign w_in_xfer  = bus.dn_gecerli_i && w_ready;
   assign w_out_xfer = r_gecerli && bus.pk_hazir_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lane    <= '0;
         r_pix_cnt <= '0;
         r_asm     <= '0;
         r_data    <= '0;
         r_keep    <= '0;
         r_son     <= 1'b0;
         r_gecerli <= 1'b0;
         r_frames  <= '0;
`ifdef DECODE_PACKER_CHECKSUM_EN
         r_state   <= ST_DATA;
         r_sum     <= '0;
`endif
      end else begin
         if (w_out_xfer) begin
            r_gecerli <= 1'b0;
            if (r_son) r_frames <= r_frames + 1'b1;
         end
         if (w_in_xfer) begin
            if (w_complete) begin
               r_data    <= w_word;
               r_keep    <= w_keep;
               r_gecerli <= 1'b1;
               r_asm     <= '0;
               r_lane    <= '0;
`ifdef DECODE_PACKER_CHECKSUM_EN
               r_son     <= 1'b0;
               if (w_last) r_state <= ST_CK_LOAD;
`else
               r_son     <= w_last;
`endif
            end else begin
               r_asm  <= w_word;
               r_lane <= r_lane + 1'b1;
            end
            r_pix_cnt <= w_last ? '0 : r_pix_cnt + 1'b1;
`ifdef DECODE_PACKER_CHECKSUM_EN
            r_sum <= r_sum + 32'(bus.dn_veri_i);
`endif
         end
`ifdef DECODE_PACKER_CHECKSUM_EN
         // Sum word loads as soon as the frame's final data word leaves the register.
         case (r_state)
            ST_CK_LOAD: if (!r_gecerli || w_out_xfer) begin
               r_data    <= WORD_W'(r_sum);
               r_keep    <= '1;
               r_son     <= 1'b1;
               r_gecerli <= 1'b1;
               r_state   <= ST_CK_OUT;
            end
            ST_CK_OUT: if (w_out_xfer) begin
               r_sum   <= '0;
               r_state <= ST_DATA;
            end
            default: ;
         endcase
`endif
      end
   end

   assign bus.dn_hazir_o       = w_ready;
   assign bus.pk_veri_o        = r_data;
   assign bus.pk_keep_o        = r_keep;
   assign bus.pk_son_o         = r_son;
   assign bus.pk_gecerli_o     = r_gecerli;
   assign bus.cerceve_sayisi_o = r_frames;
endmodule
